y86_execute_stage: RTL

- Execute stage of the 5-stage pipelined Y86-64 core; sits between the D/E and E/M pipeline registers.
- Selects ALU operands and function from E-register fields, then computes valE with Y86 arithmetic semantics.
- Owns the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX/jXX.
- Drives same-cycle forwarding outputs and holds the E/M pipeline register, with stall/bubble control.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_cond_eval.sv | 29 ++
 rtl/y86_execute_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage and its helpers:
// instruction codes, ALU function codes, status codes, register IDs, CC bit positions.
package y86_pkg;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fun_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // cc is packed as {ZF, SF, OF}
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_cond_eval.sv
// Y86 condition evaluation: maps a jXX/cmovXX function code and {ZF,SF,OF}
// to the taken/move condition. Purely combinational so fetch-side checks can reuse it.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);

    logic lt;

    // Decode the condition from the flags; unused function codes never fire
    always_comb begin
        cnd = 1'b0;
        lt  = cc[CC_SF] ^ cc[CC_OF];
        case (ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = lt | cc[CC_ZF];
            4'h2:    cnd = lt;
            4'h3:    cnd = cc[CC_ZF];
            4'h4:    cnd = ~cc[CC_ZF];
            4'h5:    cnd = ~lt;
            4'h6:    cnd = ~lt & ~cc[CC_ZF];
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Execute stage of the pipelined Y86-64 core: ALU operand/function selection,
// condition codes, Cnd evaluation, forwarding outputs and the E/M pipeline register.
// Optional performance counters are built when EXEC_PERF_CNT_EN is defined.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAT_W-1:0] E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [XLEN-1:0]   E_valC,
    input  logic [XLEN-1:0]   E_valA,
    input  logic [XLEN-1:0]   E_valB,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [STAT_W-1:0] m_stat,
    input  logic [STAT_W-1:0] W_stat,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic [XLEN-1:0]   e_valE,
    output logic [3:0]        e_dstE,
    output logic              e_Cnd,
    output logic [2:0]        cc,
`ifdef EXEC_PERF_CNT_EN
    output logic [31:0]       perf_opq_cnt,
    output logic [31:0]       perf_taken_cnt,
`endif
    output logic [STAT_W-1:0] M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [XLEN-1:0]   M_valE,
    output logic [XLEN-1:0]   M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);

    logic signed [XLEN-1:0] alu_a;
    logic signed [XLEN-1:0] alu_b;
    logic signed [XLEN-1:0] alu_res;
    alu_fun_t               alu_fun;
    logic [2:0]             new_cc;
    logic                   cc_load;

    function automatic logic signed [XLEN-1:0] alu_op(
        input alu_fun_t               fun,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        case (fun)
            ALU_SUB: alu_op = b - a;
            ALU_AND: alu_op = b & a;
            ALU_XOR: alu_op = b ^ a;
            default: alu_op = b + a;
        endcase
    endfunction

    // Two's-complement overflow; logical ops never overflow
    function automatic logic alu_ovf(
        input alu_fun_t               fun,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b,
        input logic signed [XLEN-1:0] r
    );
        case (fun)
            ALU_ADD: alu_ovf = (a[XLEN-1] == b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
            ALU_SUB: alu_ovf = (a[XLEN-1] != b[XLEN-1]) && (r[XLEN-1] != b[XLEN-1]);
            default: alu_ovf = 1'b0;
        endcase
    endfunction

    // Operand and function selection from the E-register instruction fields
    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = -XLEN'(8);
            I_RET, I_POPQ:               alu_a = XLEN'(8);
            default:                     alu_a = '0;
        endcase

        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default: alu_b = '0;
        endcase

        alu_fun = (E_icode == I_OPQ) ? alu_fun_t'(E_ifun[1:0]) : ALU_ADD;
    end

    // ALU result and the flags it would produce
    always_comb begin
        alu_res        = alu_op(alu_fun, alu_a, alu_b);
        new_cc         = '0;
        new_cc[CC_ZF]  = (alu_res == '0);
        new_cc[CC_SF]  = alu_res[XLEN-1];
        new_cc[CC_OF]  = alu_ovf(alu_fun, alu_a, alu_b, alu_res);
    end

    assign e_valE = alu_res;

    // Cnd sees the flags as they were before this instruction's own update
    y86_cond_eval u_cond (
        .ifun (E_ifun),
        .cc   (cc),
        .cnd  (e_Cnd)
    );

    // A not-taken conditional move writes nowhere
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    // Only an OPq may set flags, and never while an older instruction is excepting
    // or while the E/M register is frozen (the stalled OPq will be seen again)
    assign cc_load = (E_icode == I_OPQ) &&
                     (m_stat == STAT_W'(STAT_AOK)) &&
                     (W_stat == STAT_W'(STAT_AOK)) &&
                     !M_stall;

    // Condition-code register
    always_ff @(posedge clk) begin
        if (rst) begin
            cc <= CC_RESET;
        end else if (cc_load) begin
            cc <= new_cc;
        end
    end

    // E/M pipeline register: reset and bubble insert a NOP, stall holds
    always_ff @(posedge clk) begin
        if (rst || (!M_stall && M_bubble)) begin
            M_stat  <= STAT_W'(STAT_AOK);
            M_icode <= I_NOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    // Event counters: flag updates and taken jumps entering the memory stage
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_opq_cnt   <= '0;
            perf_taken_cnt <= '0;
        end else begin
            if (cc_load) begin
                perf_opq_cnt <= perf_opq_cnt + 32'd1;
            end
            if (!M_stall && !M_bubble && (E_icode == I_JXX) && e_Cnd) begin
                perf_taken_cnt <= perf_taken_cnt + 32'd1;
            end
        end
    end
`else
    // Without the counters the stage carries no extra state.
`endif

endmodule
